// File: rtl/tx_upmixer_sd.sv
// Transmit up-mixer: holds each baseband I/Q pair for INTERP clocks, mixes with the
// shared NCO (I*cos - Q*sin) and drives a first-order sigma-delta 1-bit RF output.
// Optional dither LFSR in the modulator is enabled by defining TX_DITHER_EN.
module tx_upmixer_sd #(
    parameter int DATA_WIDTH = 12,
    parameter int INTERP     = 64,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    input  logic signed [DATA_WIDTH-1:0] q_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] sinewave_in,
    input  logic signed [DATA_WIDTH-1:0] cosinewave_in,
    input  logic                         underrun_clr,
    output logic                         underrun,
    output logic                         rf_out
);

    localparam int PW  = 2 * DATA_WIDTH;
    localparam int DFW = PW + 1;
    localparam int AW  = DATA_WIDTH + 2;
    localparam int SW  = AW + 1;

    localparam logic signed [DFW-1:0] M_MAX = {{(DFW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DFW-1:0] M_MIN = {{(DFW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [SW-1:0]  FS_P  = {{(SW-DATA_WIDTH){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [SW-1:0]  FS_N  = {{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // ---------------------------------------------------------------- buffer
    logic signed [DATA_WIDTH-1:0] r_next_i;
    logic signed [DATA_WIDTH-1:0] r_next_q;
    logic signed [DATA_WIDTH-1:0] r_cur_i;
    logic signed [DATA_WIDTH-1:0] r_cur_q;
    logic                         r_next_full;
    logic                         r_in_ready;
    logic                         r_underrun;
    logic [CNT_WIDTH-1:0]         r_cnt;

    logic w_xfer;
    logic w_cnt_wrap;
    logic w_consume;
    logic w_next_full_d;

    assign w_xfer        = in_valid & r_in_ready;
    assign w_cnt_wrap    = (r_cnt == CNT_WIDTH'(INTERP - 1));
    assign w_consume     = enable & w_cnt_wrap;
    assign w_next_full_d = (r_next_full & ~w_consume) | w_xfer;

    // in_ready is kept as its own flop so it has no path from in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_i    <= '0;
            r_next_q    <= '0;
            r_cur_i     <= '0;
            r_cur_q     <= '0;
            r_next_full <= 1'b0;
            r_in_ready  <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_next_full <= w_next_full_d;
            r_in_ready  <= ~w_next_full_d;
            if (w_xfer) begin
                r_next_i <= i_data;
                r_next_q <= q_data;
            end
            if (w_consume) begin
                if (r_next_full) begin
                    r_cur_i <= r_next_i;
                    r_cur_q <= r_next_q;
                end else begin
                    r_cur_i <= '0;
                    r_cur_q <= '0;
                end
            end
            if (w_consume & ~r_next_full) begin
                r_underrun <= 1'b1;
            end else if (underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------- S1: products
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mult
            logic signed [DATA_WIDTH-1:0] w_op_a;
            logic signed [DATA_WIDTH-1:0] w_op_b;
            logic signed [PW-1:0]         r_prod;

            assign w_op_a = (gi == 0) ? r_cur_i : r_cur_q;
            assign w_op_b = (gi == 0) ? cosinewave_in : sinewave_in;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_prod <= '0;
                end else if (enable) begin
                    r_prod <= w_op_a * w_op_b;
                end
            end
        end
    endgenerate

    // ---------------------------------------------------------------- S2: difference, scale, saturate
    logic signed [DFW-1:0]        w_diff;
    logic signed [DFW-1:0]        w_shift;
    logic signed [DATA_WIDTH-1:0] w_m_sat;
    logic signed [DATA_WIDTH-1:0] r_m;

    assign w_diff  = {g_mult[0].r_prod[PW-1], g_mult[0].r_prod}
                   - {g_mult[1].r_prod[PW-1], g_mult[1].r_prod};
    assign w_shift = w_diff >>> (DATA_WIDTH - 1);

    // Full-scale products can land at up to twice the sample range after scaling.
    always_comb begin
        w_m_sat = w_shift[DATA_WIDTH-1:0];
        if (w_shift > M_MAX) begin
            w_m_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (w_shift < M_MIN) begin
            w_m_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m <= '0;
        end else if (enable) begin
            r_m <= w_m_sat;
        end
    end

    // ---------------------------------------------------------------- S3: sigma-delta modulator
    logic signed [AW-1:0] r_e;
    logic                 r_rf;
    logic signed [SW-1:0] w_e_ext;
    logic signed [SW-1:0] w_m_ext;
    logic signed [SW-1:0] w_fb;
    logic signed [SW-1:0] w_sum;

    assign w_e_ext = {{(SW-AW){r_e[AW-1]}}, r_e};
    assign w_m_ext = {{(SW-DATA_WIDTH){r_m[DATA_WIDTH-1]}}, r_m};
    assign w_fb    = r_rf ? FS_P : FS_N;

`ifdef TX_DITHER_EN
    logic [14:0]          r_lfsr;
    logic signed [SW-1:0] w_dither;

    assign w_dither = r_lfsr[0] ? {{(SW-1){1'b0}}, 1'b1} : {SW{1'b1}};
    assign w_sum    = w_e_ext + w_m_ext - w_fb + w_dither;

    // x^15 + x^14 + 1 Fibonacci LFSR; breaks idle tones on constant inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 15'h0001;
        end else if (enable) begin
            r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
        end
    end
`else
    assign w_sum = w_e_ext + w_m_ext - w_fb;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e  <= '0;
            r_rf <= 1'b0;
        end else if (enable) begin
            r_e  <= w_sum[AW-1:0];
            r_rf <= ~w_sum[SW-1];
        end
    end

    assign in_ready = r_in_ready;
    assign underrun = r_underrun;
    assign rf_out   = r_rf;

endmodule
